// File: rtl/md_ram_pkg.sv
// Shared constants and state encoding for the prediction-mode RAM controller.
// Optional feature macro: MD_RAM_RD_FWD_EN (same-address write-to-read forwarding).
package md_ram_pkg;

  localparam int ADR_WD = 6;   // RAM address width
  localparam int ADR    = 64;  // number of RAM entries, one per 8x8 block of a 64x64 LCU
  localparam int DAT_WD = 6;   // intra mode width

  localparam logic [DAT_WD-1:0] MODE_DC = DAT_WD'(1);
  localparam logic [DAT_WD-1:0] CLR_VAL = MODE_DC;

  // Last address of the clear sweep; the counter stops here instead of wrapping.
  localparam logic [ADR_WD-1:0] CLR_LAST = ADR_WD'(ADR - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/md_ram_ctrl_if.sv
// Request-side bus of md_ram_ctrl: mode-writer port and neighbour-lookup reader port.
// Optional feature macro: MD_RAM_RD_FWD_EN (no effect on this interface).
interface md_ram_ctrl_if;
  import md_ram_pkg::*;

  logic              wr_val;
  logic [ADR_WD-1:0] wr_adr;
  logic [DAT_WD-1:0] wr_dat;
  logic              wr_rdy;

  logic              rd_val;
  logic [ADR_WD-1:0] rd_adr;
  logic              rd_rdy;
  logic              rd_dat_val;
  logic [DAT_WD-1:0] rd_dat;

  // Upstream clients (writer and reader) drive requests.
  modport master (
    output wr_val, wr_adr, wr_dat, rd_val, rd_adr,
    input  wr_rdy, rd_rdy, rd_dat_val, rd_dat
  );

  // The controller accepts requests and returns read data.
  modport slave (
    input  wr_val, wr_adr, wr_dat, rd_val, rd_adr,
    output wr_rdy, rd_rdy, rd_dat_val, rd_dat
  );

endinterface

// File: rtl/md_ram_ctrl.sv
// Access controller for the 64x6 single-port intra-mode RAM: clear sweep at LCU
// start, then write-over-read arbitration with a 1-cycle read return path.
// Optional feature macro: MD_RAM_RD_FWD_EN -- a same-cycle write and read to the
// same address are both accepted; the read returns the written data next cycle.
module md_ram_ctrl
  import md_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start_i,
  output logic              clr_done_o,
  md_ram_ctrl_if.slave      req_if,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  state_e            state_q, state_d;
  logic [ADR_WD-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADR_WD-1:0] adr_q;       // last driven RAM address, held while idle
  logic              rd_pend_q;   // a read was accepted last cycle
  logic [DAT_WD-1:0] rd_dat_q;    // last returned read data
  logic [DAT_WD-1:0] rd_dat_src;
  logic              wr_rdy, rd_rdy, rd_acc;

`ifdef MD_RAM_RD_FWD_EN
  logic              fwd_hit;
  logic              fwd_q;
  logic [DAT_WD-1:0] fwd_dat_q;
`endif

  // Next-state, handshake and RAM-side control for the current cycle.
  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_done_o   = 1'b0;
    wr_rdy       = 1'b0;
    rd_rdy       = 1'b0;
    rd_acc       = 1'b0;
    ram_wr_ena_o = 1'b1;
    ram_rd_ena_o = 1'b1;
    ram_adr_o    = adr_q;
    ram_wr_dat_o = '0;
`ifdef MD_RAM_RD_FWD_EN
    fwd_hit      = 1'b0;
`endif
    if (rst) begin
      ram_adr_o = '0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          ram_wr_ena_o = 1'b0;
          ram_adr_o    = clr_cnt_q;
          ram_wr_dat_o = CLR_VAL;
          if (clr_cnt_q == CLR_LAST) begin
            clr_done_o = 1'b1;
            state_d    = ST_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_start_i) begin
            // A new LCU outranks any same-cycle access.
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else begin
            wr_rdy = 1'b1;
`ifdef MD_RAM_RD_FWD_EN
            fwd_hit = req_if.wr_val && req_if.rd_val && (req_if.wr_adr == req_if.rd_adr);
            rd_rdy  = !req_if.wr_val || fwd_hit;
`else
            rd_rdy  = !req_if.wr_val;
`endif
            rd_acc = req_if.rd_val && rd_rdy;
            if (req_if.wr_val) begin
              ram_wr_ena_o = 1'b0;
              ram_adr_o    = req_if.wr_adr;
              ram_wr_dat_o = req_if.wr_dat;
            end else if (rd_acc) begin
              ram_rd_ena_o = 1'b0;
              ram_adr_o    = req_if.rd_adr;
            end
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  // State, clear counter, address hold and read-return registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      adr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_dat_q  <= '0;
`ifdef MD_RAM_RD_FWD_EN
      fwd_q     <= 1'b0;
      fwd_dat_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      adr_q     <= ram_adr_o;
      rd_pend_q <= rd_acc;
      if (rd_pend_q) rd_dat_q <= rd_dat_src;
`ifdef MD_RAM_RD_FWD_EN
      fwd_q     <= fwd_hit;
      if (fwd_hit) fwd_dat_q <= req_if.wr_dat;
`endif
    end
  end

`ifdef MD_RAM_RD_FWD_EN
  assign rd_dat_src = fwd_q ? fwd_dat_q : ram_rd_dat_i;
`else
  assign rd_dat_src = ram_rd_dat_i;
`endif

  assign req_if.wr_rdy     = wr_rdy;
  assign req_if.rd_rdy     = rd_rdy;
  assign req_if.rd_dat_val = rd_pend_q && !rst;
  assign req_if.rd_dat     = rst ? '0 : (rd_pend_q ? rd_dat_src : rd_dat_q);

endmodule

// File: doc/md_ram_ctrl.md
Name: md_ram_ctrl

Overview:
- Access controller for the 64-entry x 6-bit single-port prediction-mode RAM that holds one intra mode per 8x8 block of a 64x64 LCU.
- Drives the RAM's address, active-low write/read enables and write data.
- Arbitrates an upstream mode-writer port against a downstream neighbour-lookup reader port, used for MPM derivation.
- Runs an LCU-start clear sweep that fills all entries with a default mode.

Parameters:
- ADR_WD, 6, RAM address width.
- ADR, 64, number of RAM entries.
- DAT_WD, 6, mode width.
- CLR_VAL, 1, value written to every entry during clear (DC mode).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clr_start_i  in  1  one-cycle pulse: start clear sweep.
- clr_done_o  out  1  one-cycle pulse when the last clear write issues.
- wr_val_i  in  1  write request.
- wr_adr_i  in  ADR_WD  write address.
- wr_dat_i  in  DAT_WD  write data.
- wr_rdy_o  out  1  write accepted when wr_val_i && wr_rdy_o.
- rd_val_i  in  1  read request.
- rd_adr_i  in  ADR_WD  read address.
- rd_rdy_o  out  1  read accepted when rd_val_i && rd_rdy_o.
- rd_dat_val_o  out  1  read data valid.
- rd_dat_o  out  DAT_WD  read data.
- ram_adr_o  out  ADR_WD  RAM address.
- ram_wr_ena_o  out  1  RAM write enable, low active.
- ram_wr_dat_o  out  DAT_WD  RAM write data.
- ram_rd_ena_o  out  1  RAM read enable, low active.
- ram_rd_dat_i  in  DAT_WD  RAM read data, valid the cycle after a read.

Behaviour:
- Reset values:
  - rst=1 forces state CLEAR with clr_cnt=0.
  - Outputs during reset: ram_wr_ena_o=1, ram_rd_ena_o=1, ram_adr_o=0, ram_wr_dat_o=0.
  - Outputs during reset: clr_done_o=0, rd_dat_val_o=0, rd_dat_o=0, wr_rdy_o=0, rd_rdy_o=0.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each cycle: ram_wr_ena_o=0, ram_adr_o=clr_cnt, ram_wr_dat_o=CLR_VAL, clr_cnt++.
  - At clr_cnt==ADR-1: clr_done_o=1 in that same cycle, next state RUN.
  - wr_rdy_o=rd_rdy_o=0 throughout; clr_start_i is ignored.
  - The sweep takes exactly ADR cycles.
- RUN:
  - wr_rdy_o=1.
  - rd_rdy_o = !wr_val_i, so a write has priority over a read.
  - An accepted write drives ram_wr_ena_o=0, ram_adr_o=wr_adr_i, ram_wr_dat_o=wr_dat_i combinationally, in the same cycle.
  - An accepted read drives ram_rd_ena_o=0, ram_adr_o=rd_adr_i.
  - ram_wr_ena_o and ram_rd_ena_o are never both 0 in the same cycle.
  - With no request, both enables are 1 and ram_adr_o holds its last value.
- clr_start_i in RUN:
  - Takes priority over a same-cycle write or read: both rdy outputs read 0 that cycle and no RAM access is made.
  - Next state CLEAR, clr_cnt=0.
- Read latency is 1 cycle:
  - rd_dat_val_o=1 in the cycle after acceptance, with rd_dat_o=ram_rd_dat_i.
  - Otherwise rd_dat_val_o=0 and rd_dat_o holds the last valid data in a register.
- A read accepted in the cycle before a clear begins still returns its data.
- A read of an address written in the previous cycle returns the new data, because the RAM is write-through across cycles.
- Back-to-back reads sustain 1 read per cycle.
- Address wrap: clr_cnt is ADR_WD bits and stops at ADR-1; it is not free-running.
- rst asserted mid-clear or mid-read:
  - Restarts the clear sweep from 0.
  - Drops any pending rd_dat_val_o.

Optional Feature:
- Macro: MD_RAM_RD_FWD_EN.
- Defined:
  - In RUN, when wr_val_i && rd_val_i && wr_adr_i==rd_adr_i, the read is also accepted (rd_rdy_o=1).
  - The write issues to the RAM.
  - Next cycle rd_dat_val_o=1 and rd_dat_o = the forwarded wr_dat_i, taken from a registered copy.
  - With different addresses the read still stalls.
- Undefined: rd_rdy_o = !wr_val_i unconditionally.

Decomposition:
- Shared package md_ram_pkg holds:
  - ADR_WD, DAT_WD, ADR constants.
  - CLR_VAL as mode constant MODE_DC=1.
  - State encoding: ST_CLEAR=1'b0, ST_RUN=1'b1.
- No sub-module is needed. The RAM wrapper is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle -> 64 consecutive cycles of ram_wr_ena_o=0 at addresses 0..63 with data 1; clr_done_o pulses only in cycle 64; rdy outputs go to 1 in cycle 65; reads of addr 0 and addr 63 return 1.
- Write addr 5 = 6'd34, next cycle read addr 5 -> rd_dat_val_o=1 one cycle after acceptance with rd_dat_o=34; rd_dat_o holds 34 afterwards.
- Same-cycle write addr 10 = 7 and read addr 20 -> read stalls (rd_rdy_o=0); read accepted next cycle returns the prior content of addr 20 (1 after clear).
- Same-cycle write addr 12 = 9 and read addr 12 -> with MD_RAM_RD_FWD_EN, both accepted and rd_dat_o=9 next cycle; without the macro, the read stalls one cycle and then returns 9.
- clr_start_i during a stream of reads (read accepted in cycle N, clear pulse in cycle N+1) -> rd_dat_val_o still fires in N+1; 64 clear cycles follow; an earlier-written addr 5 then reads 1.
- rst asserted at clear cycle 30 -> sweep restarts at addr 0; clr_done_o is seen exactly 64 cycles after rst is released.
